// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB, drives datapath enables/selects, counts retires.
// Latency 2 (jumps/nop/illegal), 3 (beq), 4 (alu/sw), 5 (lw) cycles; no backpressure, free-running.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             PCWr,
  output logic             IRWr,
  output logic [1:0]       NPCSel,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic [1:0]       WDSel,
  output logic             ALUSrc,
  output logic [2:0]       ALUOp,
  output logic [1:0]       EXTOp,
  output logic             MemWr,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7
  } state_t;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] npc_sel;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       mem_wr;
    logic       illegal;
    logic       retire;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  ctl;

  logic is_rtype, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic uses_exe, legal;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_addu  = is_rtype && (funct == FN_ADDU);
  assign is_subu  = is_rtype && (funct == FN_SUBU);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_nop   = is_rtype && (funct == FN_NOP);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign uses_exe = is_addu || is_subu || is_ori || is_lui || is_lw || is_sw;
  assign legal    = uses_exe || is_beq || is_j || is_jal || is_jr || is_nop;

  // ALU/extender settings chosen in EXE, held through MEM_* and WB_*.
  logic [2:0] ex_alu_op;
  logic       ex_alu_src;
  logic [1:0] ex_ext_op;

  always_comb begin
    ex_alu_op  = 3'b000;
    ex_alu_src = 1'b0;
    ex_ext_op  = 2'b00;
    if (is_subu) begin
      ex_alu_op = 3'b001;
    end else if (is_ori) begin
      ex_alu_op  = 3'b010;
      ex_alu_src = 1'b1;
      ex_ext_op  = 2'b01;
    end else if (is_lui) begin
      ex_alu_op  = 3'b011;
      ex_alu_src = 1'b1;
      ex_ext_op  = 2'b10;
    end else if (is_lw || is_sw) begin
      ex_alu_src = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    if (state inside {S_EXE, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM}) begin
      ctl.alu_op  = ex_alu_op;
      ctl.alu_src = ex_alu_src;
      ctl.ext_op  = ex_ext_op;
    end
    case (state)
      S_FETCH: begin
        ctl.pc_wr = 1'b1;
        ctl.ir_wr = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (uses_exe) begin
          state_nxt = S_EXE;
        end else if (is_beq) begin
          state_nxt = S_BRANCH;
        end else begin
          state_nxt  = S_FETCH;
          ctl.retire = 1'b1;
          ctl.illegal = !legal;
          if (is_j || is_jal) begin
            ctl.pc_wr   = 1'b1;
            ctl.npc_sel = 2'b10;
          end
          if (is_jal) begin
            ctl.reg_wr  = 1'b1;
            ctl.reg_dst = 2'b10;
            ctl.wd_sel  = 2'b10;
          end
          if (is_jr) begin
            ctl.pc_wr   = 1'b1;
            ctl.npc_sel = 2'b11;
          end
        end
      end
      S_EXE: begin
        if (is_lw)      state_nxt = S_MEM_RD;
        else if (is_sw) state_nxt = S_MEM_WR;
        else            state_nxt = S_WB_ALU;
      end
      S_MEM_RD: state_nxt = S_WB_MEM;
      S_MEM_WR: begin
        ctl.mem_wr = 1'b1;
        ctl.retire = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_WB_ALU: begin
        ctl.reg_wr  = 1'b1;
        ctl.reg_dst = is_rtype ? 2'b01 : 2'b00;
        ctl.retire  = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_WB_MEM: begin
        ctl.reg_wr = 1'b1;
        ctl.wd_sel = 2'b01;
        ctl.retire = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_op  = 3'b001;
        ctl.npc_sel = 2'b01;
        ctl.pc_wr   = zero;
        ctl.retire  = 1'b1;
        state_nxt   = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    if (reset) ctl = '0;
  end

  always_ff @(posedge clk) begin
    if (reset)           instr_cnt <= '0;
    else if (ctl.retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  assign PCWr    = ctl.pc_wr;
  assign IRWr    = ctl.ir_wr;
  assign NPCSel  = ctl.npc_sel;
  assign RegWr   = ctl.reg_wr;
  assign RegDst  = ctl.reg_dst;
  assign WDSel   = ctl.wd_sel;
  assign ALUSrc  = ctl.alu_src;
  assign ALUOp   = ctl.alu_op;
  assign EXTOp   = ctl.ext_op;
  assign MemWr   = ctl.mem_wr;
  assign illegal = ctl.illegal;
  assign retire  = ctl.retire;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: stimulus queues per-cycle expected outputs, a negedge monitor pops and compares.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        PCWr, IRWr, RegWr, ALUSrc, MemWr, illegal, retire;
  logic [1:0]  NPCSel, RegDst, WDSel, EXTOp;
  logic [2:0]  ALUOp;
  logic [31:0] instr_cnt;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .NPCSel(NPCSel), .RegWr(RegWr), .RegDst(RegDst),
    .WDSel(WDSel), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .EXTOp(EXTOp), .MemWr(MemWr),
    .illegal(illegal), .retire(retire), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pcwr;
    logic        irwr;
    logic [1:0]  npc;
    logic        regwr;
    logic [1:0]  rdst;
    logic [1:0]  wds;
    logic        asrc;
    logic [2:0]  aop;
    logic [1:0]  eop;
    logic        memwr;
    logic        ill;
    logic        ret;
    logic [31:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    exp_cnt  = 0;

  always @(negedge clk) begin
    obs_t  e, g;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = '{pcwr: PCWr, irwr: IRWr, npc: NPCSel, regwr: RegWr, rdst: RegDst,
            wds: WDSel, asrc: ALUSrc, aop: ALUOp, eop: EXTOp, memwr: MemWr,
            ill: illegal, ret: retire, cnt: instr_cnt};
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", t, g, e);
    end
  end

  task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                     input logic [5:0] fn, input logic z,
                     input logic pcwr, input logic irwr, input logic [1:0] npc,
                     input logic regwr, input logic [1:0] rdst, input logic [1:0] wds,
                     input logic asrc, input logic [2:0] aop, input logic [1:0] eop,
                     input logic memwr, input logic ill, input logic ret);
    obs_t e;
    reset  = rst;
    opcode = op;
    funct  = fn;
    zero   = z;
    e = '{pcwr: pcwr, irwr: irwr, npc: npc, regwr: regwr, rdst: rdst, wds: wds,
          asrc: asrc, aop: aop, eop: eop, memwr: memwr, ill: ill, ret: ret,
          cnt: 32'(exp_cnt)};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (rst)      exp_cnt = 0;
    else if (ret) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
    cyc({tag, "_fetch"}, 0, op, fn, z, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0, 0, 0);
  endtask

  task automatic quiet(input string tag, input logic rst, input logic [5:0] op, input logic [5:0] fn, input logic z);
    cyc(tag, rst, op, fn, z, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0, 0, 0);
  endtask

  initial begin
    reset = 1; opcode = 0; funct = 0; zero = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) quiet("reset", 1, 6'h00, 6'h00, 0);

    // addu aborted by reset in EXE; count is zero either way here
    fetch("abort", 6'b000000, 6'b100001, 0);
    quiet("abort_decode", 0, 6'b000000, 6'b100001, 0);
    quiet("abort_exe_rst", 1, 6'b000000, 6'b100001, 0);

    fetch("ori", 6'b001101, 6'h00, 0);
    quiet("ori_decode", 0, 6'b001101, 6'h00, 0);
    cyc("ori_exe", 0, 6'b001101, 6'h00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b010, 2'b01, 0, 0, 0);
    cyc("ori_wb",  0, 6'b001101, 6'h00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 1, 3'b010, 2'b01, 0, 0, 1);

    fetch("lui", 6'b001111, 6'h00, 0);
    quiet("lui_decode", 0, 6'b001111, 6'h00, 0);
    cyc("lui_exe", 0, 6'b001111, 6'h00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b011, 2'b10, 0, 0, 0);
    cyc("lui_wb",  0, 6'b001111, 6'h00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 1, 3'b011, 2'b10, 0, 0, 1);

    fetch("addu", 6'b000000, 6'b100001, 0);
    quiet("addu_decode", 0, 6'b000000, 6'b100001, 0);
    cyc("addu_exe", 0, 6'b000000, 6'b100001, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0, 0, 0);
    cyc("addu_wb",  0, 6'b000000, 6'b100001, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'b000, 2'b00, 0, 0, 1);

    fetch("subu", 6'b000000, 6'b100011, 0);
    quiet("subu_decode", 0, 6'b000000, 6'b100011, 0);
    cyc("subu_exe", 0, 6'b000000, 6'b100011, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b001, 2'b00, 0, 0, 0);
    cyc("subu_wb",  0, 6'b000000, 6'b100011, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 3'b001, 2'b00, 0, 0, 1);

    fetch("lw", 6'b100011, 6'h00, 0);
    quiet("lw_decode", 0, 6'b100011, 6'h00, 0);
    cyc("lw_exe",   0, 6'b100011, 6'h00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 2'b00, 0, 0, 0);
    cyc("lw_memrd", 0, 6'b100011, 6'h00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 2'b00, 0, 0, 0);
    cyc("lw_wbmem", 0, 6'b100011, 6'h00, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 1, 3'b000, 2'b00, 0, 0, 1);

    fetch("sw", 6'b101011, 6'h00, 0);
    quiet("sw_decode", 0, 6'b101011, 6'h00, 0);
    cyc("sw_exe",   0, 6'b101011, 6'h00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 2'b00, 0, 0, 0);
    cyc("sw_memwr", 0, 6'b101011, 6'h00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 3'b000, 2'b00, 1, 0, 1);

    fetch("beq_t", 6'b000100, 6'h00, 1);
    quiet("beq_t_decode", 0, 6'b000100, 6'h00, 1);
    cyc("beq_t_branch", 0, 6'b000100, 6'h00, 1, 1, 0, 2'b01, 0, 2'b00, 2'b00, 0, 3'b001, 2'b00, 0, 0, 1);
    fetch("beq_n", 6'b000100, 6'h00, 0);
    quiet("beq_n_decode", 0, 6'b000100, 6'h00, 0);
    cyc("beq_n_branch", 0, 6'b000100, 6'h00, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 3'b001, 2'b00, 0, 0, 1);

    fetch("jal", 6'b000011, 6'h00, 0);
    cyc("jal_decode", 0, 6'b000011, 6'h00, 0, 1, 0, 2'b10, 1, 2'b10, 2'b10, 0, 3'b000, 2'b00, 0, 0, 1);
    fetch("jr", 6'b000000, 6'b001000, 0);
    cyc("jr_decode",  0, 6'b000000, 6'b001000, 0, 1, 0, 2'b11, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0, 0, 1);
    fetch("j", 6'b000010, 6'h00, 0);
    cyc("j_decode",   0, 6'b000010, 6'h00, 0, 1, 0, 2'b10, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0, 0, 1);
    fetch("nop", 6'b000000, 6'b000000, 0);
    cyc("nop_decode", 0, 6'b000000, 6'b000000, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0, 0, 1);

    fetch("ill_op", 6'b111111, 6'h00, 0);
    cyc("ill_op_decode", 0, 6'b111111, 6'h00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0, 1, 1);
    fetch("ill_fn", 6'b000000, 6'b111111, 0);
    cyc("ill_fn_decode", 0, 6'b000000, 6'b111111, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0, 1, 1);
    fetch("after_ill", 6'b000000, 6'h00, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the P-series MIPS core. It sequences one shared datapath (PC/NPC, IR, GRF, EXT, ALU, DM) through FETCH/DECODE/EXE/MEM/WB states. It produces every write enable and mux select, including `EXTOp` for the immediate extender (00 sign, 01 zero, 10 lui-shift). It also counts retired instructions.

## Interface
- `CNT_W`, 32: width of retired-instruction counter.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `opcode`  in  6: IR[31:26], stable from the cycle after FETCH.
- `funct`  in  6: IR[5:0].
- `zero`  in  1: ALU equality flag (A==B), valid in BRANCH.
- `PCWr`  out  1: PC load enable.
- `IRWr`  out  1: IR load enable.
- `NPCSel`  out  2: 00 PC+4, 01 branch target, 10 j/jal target, 11 GRF[rs].
- `RegWr`  out  1: GRF write enable.
- `RegDst`  out  2: 00 rt, 01 rd, 10 $31.
- `WDSel`  out  2: 00 ALU result register, 01 DM read-data register, 10 PC+4.
- `ALUSrc`  out  1: 0 GRF[rt], 1 EXTimm.
- `ALUOp`  out  3: 000 add, 001 sub, 010 or, 011 pass B.
- `EXTOp`  out  2: 00 sign, 01 zero, 10 lui.
- `MemWr`  out  1: DM write enable.
- `illegal`  out  1: one-cycle pulse, unknown instruction decoded.
- `retire`  out  1: one-cycle pulse on an instruction's final state.
- `instr_cnt`  out  CNT_W: retired-instruction count.

## Operation
- Supported instructions:
  - R-type (op 000000): addu f=100001, subu f=100011, jr f=001000, f=000000 treated as nop.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States (binary encoded, 4-bit register): FETCH, DECODE, EXE, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH.
- Transitions:
  - FETCH → DECODE unconditionally.
  - DECODE → EXE for addu/subu/ori/lui/lw/sw; → BRANCH for beq; → FETCH for j/jal/jr/nop/illegal.
  - EXE → MEM_RD (lw), MEM_WR (sw), WB_ALU (others).
  - MEM_RD → WB_MEM; MEM_WR, WB_ALU, WB_MEM, BRANCH → FETCH.
- Outputs are combinational from state + opcode/funct. Unlisted signals are 0. `ALUOp`/`ALUSrc`/`EXTOp` hold their EXE values through MEM_* and WB_*.
  - FETCH: PCWr=1, IRWr=1, NPCSel=00.
  - DECODE, j: PCWr=1, NPCSel=10.
  - DECODE, jal: PCWr=1, NPCSel=10, RegWr=1, RegDst=10, WDSel=10.
  - DECODE, jr: PCWr=1, NPCSel=11.
  - EXE: addu ALUOp=000, ALUSrc=0; subu 001, ALUSrc=0; ori 010, ALUSrc=1, EXTOp=01; lui 011, ALUSrc=1, EXTOp=10; lw/sw 000, ALUSrc=1, EXTOp=00.
  - MEM_WR: MemWr=1.
  - WB_ALU: RegWr=1, WDSel=00, RegDst=01 for R-type, 00 otherwise.
  - WB_MEM: RegWr=1, WDSel=01, RegDst=00.
  - BRANCH: ALUOp=001, ALUSrc=0, EXTOp=00, NPCSel=01, PCWr=zero.
- `retire` is asserted in exactly the last state of every instruction, including nop and illegal: MEM_WR, WB_ALU, WB_MEM, BRANCH, and DECODE when the next state is FETCH. `instr_cnt` increments on that edge and wraps from all-ones to 0.
- `illegal` is asserted in DECODE for any unlisted opcode/funct; the instruction then retires as a nop.

## Timing
- Reset: while `reset`=1, the state register loads FETCH, `instr_cnt` loads 0, and all enables (PCWr, IRWr, RegWr, MemWr), `retire` and `illegal` are forced 0. Selects read 0.
- The first fetch occurs in the first cycle with `reset`=0.
- Reset asserted mid-instruction aborts it on that edge: no retire, no count.
- Latency in cycles: j/jal/jr/nop/illegal 2; beq 3; addu/subu/ori/lui/sw 4; lw 5.
- Every write enable is high for exactly one cycle per instruction. PCWr is the exception: it fires twice for jumps and taken beq (FETCH, then DECODE or BRANCH).

## Test plan
- Reset held 3 cycles, then released → state FETCH; PCWr=IRWr=1 in the first released cycle; `instr_cnt`=0.
- Sequence ori, lui, addu, subu → each retires after 4 cycles. ori shows EXTOp=01, lui EXTOp=10, addu RegDst=01. `instr_cnt`=4 after 16 cycles.
- lw then sw → lw passes FETCH, DECODE, EXE, MEM_RD, WB_MEM with WDSel=01 and RegWr only in WB_MEM. sw shows MemWr=1 only in cycle 4, EXTOp=00.
- beq with zero=1, then with zero=0 → BRANCH asserts PCWr=1/NPCSel=01 in the first case and PCWr=0 in the second; both retire in 3 cycles.
- jal, then jr (f=001000) → jal's DECODE has RegWr=1, RegDst=10, WDSel=10, PCWr=1, NPCSel=10; jr's DECODE has NPCSel=11; each takes 2 cycles.
- Opcode 111111, and reset asserted during EXE of addu → the first gives `illegal` and `retire` pulses with no RegWr/MemWr. The second returns to FETCH with `instr_cnt` unchanged and no RegWr.
